// File: rtl/fpu_ieee754_divide.sv
//------------------------------------------------------------------------------
// fpu_ieee754_divide
//
// Sequential 80-bit extended-precision divider (operand_a / operand_b).
// Uses radix-2 restoring division and produces one quotient bit per clock.
// Operand format: [79] sign, [78:64] exponent (bias 16383), [63] explicit
// integer bit, [62:0] fraction.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high; aborts any operation in flight
//   enable           start request, sampled only while idle
//   operand_a        dividend
//   operand_b        divisor
//   rounding_mode    00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
//   result           quotient, held until the next completion
//   done             one-cycle completion pulse
//   flag_invalid     NaN operand, 0/0, inf/inf, denormal or unnormal operand
//   flag_div_by_zero finite nonzero divided by zero
//   flag_overflow    result exponent reached 7FFF
//   flag_underflow   result exponent <= 0 (flushed to signed zero)
//   flag_inexact     result was rounded
//
// Configuration macro:
//   FPU_DIV_EARLY_EXIT_EN  when defined, the divide loop stops as soon as the
//                          partial remainder is zero; the quotient is then
//                          left-aligned so results and flags are unchanged.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fpu_ieee754_divide #(
    parameter int QBITS = 68
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [79:0] operand_a,
    input  logic [79:0] operand_b,
    input  logic [1:0]  rounding_mode,
    output logic [79:0] result,
    output logic        done,
    output logic        flag_invalid,
    output logic        flag_div_by_zero,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    localparam logic [14:0] EXP_ALL1  = 15'h7FFF;
    localparam logic [63:0] MANT_INT  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MANT_QNAN = 64'hC000_0000_0000_0000;
    localparam logic [79:0] QNAN      = {1'b0, EXP_ALL1, MANT_QNAN};
    localparam int          CNT_W     = $clog2(QBITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORMALIZE,
        S_ROUND,
        S_PACK
    } state_t;

    state_t                state_reg;
    logic [79:0]           a_reg;
    logic [79:0]           b_reg;
    logic [1:0]            rmode_reg;
    logic                  sign_reg;
    logic signed [16:0]    exp_reg;
    logic [64:0]           rem_reg;
    logic [QBITS-1:0]      q_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [63:0]           mant_reg;
    logic                  guard_reg;
    logic                  round_reg;
    logic                  sticky_reg;
    logic                  inexact_reg;

    //--------------------------------------------------------------------------
    // Operand classification (operands are latched at start)
    //--------------------------------------------------------------------------
    logic [14:0] exp_a, exp_b;
    logic [63:0] mant_a, mant_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_unnorm, b_unnorm;
    logic        sign_q;
    logic signed [16:0] exp_diff;

    assign exp_a  = a_reg[78:64];
    assign exp_b  = b_reg[78:64];
    assign mant_a = a_reg[63:0];
    assign mant_b = b_reg[63:0];
    assign sign_q = a_reg[79] ^ b_reg[79];

    // Exponent 7FFF is infinity only with the bare integer bit; every other
    // mantissa (including all-zero pseudo-infinity) is treated as NaN.
    assign a_nan    = (exp_a == EXP_ALL1) && (mant_a != MANT_INT);
    assign b_nan    = (exp_b == EXP_ALL1) && (mant_b != MANT_INT);
    assign a_inf    = (exp_a == EXP_ALL1) && (mant_a == MANT_INT);
    assign b_inf    = (exp_b == EXP_ALL1) && (mant_b == MANT_INT);
    assign a_zero   = (mant_a == 64'd0);
    assign b_zero   = (mant_b == 64'd0);
    assign a_unnorm = (mant_a != 64'd0) && !mant_a[63];
    assign b_unnorm = (mant_b != 64'd0) && !mant_b[63];

    assign exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 17'sd16383;

    //--------------------------------------------------------------------------
    // One restoring-division step
    //--------------------------------------------------------------------------
    logic [64:0]      divisor_ext;
    logic             q_bit;
    logic [64:0]      rem_step;
    logic [64:0]      rem_shift;
    logic [QBITS-1:0] q_shift;
    logic [QBITS-1:0] q_div_next;
    logic             div_last;

    assign divisor_ext = {1'b0, mant_b};
    assign q_bit       = (rem_reg >= divisor_ext);
    assign rem_step    = q_bit ? (rem_reg - divisor_ext) : rem_reg;
    // rem_step < divisor < 2^64, so the bit shifted out is always zero.
    assign rem_shift   = rem_step << 1;
    assign q_shift     = {q_reg[QBITS-2:0], q_bit};

`ifdef FPU_DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] shift_left;
    logic             early_done;

    assign shift_left = LAST_ITER - count_reg;
    assign early_done = (rem_step == 65'd0);
    // Remaining quotient bits would all be zero: align as if the loop ran out.
    assign q_div_next = early_done ? (q_shift << shift_left) : q_shift;
    assign div_last   = early_done || (count_reg == LAST_ITER);
`else
    assign q_div_next = q_shift;
    assign div_last   = (count_reg == LAST_ITER);
`endif

    //--------------------------------------------------------------------------
    // Normalization: quotient lies in (0.5, 2)
    //--------------------------------------------------------------------------
    logic [QBITS-1:0]   q_norm;
    logic signed [16:0] exp_norm;
    logic               sticky_norm;

    assign q_norm      = q_reg[QBITS-1] ? q_reg : (q_reg << 1);
    assign exp_norm    = q_reg[QBITS-1] ? exp_reg : (exp_reg - 17'sd1);
    assign sticky_norm = (|q_norm[QBITS-67:0]) | (|rem_reg);

    //--------------------------------------------------------------------------
    // Rounding decision
    //--------------------------------------------------------------------------
    logic        any_lost;
    logic        round_up;
    logic [64:0] mant_inc;

    assign any_lost = guard_reg | round_reg | sticky_reg;
    assign mant_inc = {1'b0, mant_reg} + 65'd1;

    always_comb begin
        round_up = 1'b0;
        case (rmode_reg)
            2'b00:   round_up = guard_reg & (round_reg | sticky_reg | mant_reg[0]);
            2'b01:   round_up = sign_reg & any_lost;
            2'b10:   round_up = ~sign_reg & any_lost;
            default: round_up = 1'b0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Control FSM with registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            a_reg            <= '0;
            b_reg            <= '0;
            rmode_reg        <= '0;
            sign_reg         <= 1'b0;
            exp_reg          <= '0;
            rem_reg          <= '0;
            q_reg            <= '0;
            count_reg        <= '0;
            mant_reg         <= '0;
            guard_reg        <= 1'b0;
            round_reg        <= 1'b0;
            sticky_reg       <= 1'b0;
            inexact_reg      <= 1'b0;
            result           <= '0;
            done             <= 1'b0;
            flag_invalid     <= 1'b0;
            flag_div_by_zero <= 1'b0;
            flag_overflow    <= 1'b0;
            flag_underflow   <= 1'b0;
            flag_inexact     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        a_reg            <= operand_a;
                        b_reg            <= operand_b;
                        rmode_reg        <= rounding_mode;
                        // Flags of the previous operation stay visible until here.
                        flag_invalid     <= 1'b0;
                        flag_div_by_zero <= 1'b0;
                        flag_overflow    <= 1'b0;
                        flag_underflow   <= 1'b0;
                        flag_inexact     <= 1'b0;
                        state_reg        <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    sign_reg  <= sign_q;
                    exp_reg   <= exp_diff;
                    rem_reg   <= {1'b0, mant_a};
                    q_reg     <= '0;
                    count_reg <= '0;
                    state_reg <= S_IDLE;
                    if (a_nan || b_nan || a_unnorm || b_unnorm ||
                        (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result       <= QNAN;
                        flag_invalid <= 1'b1;
                        done         <= 1'b1;
                    end else if (a_inf) begin
                        result <= {sign_q, EXP_ALL1, MANT_INT};
                        done   <= 1'b1;
                    end else if (b_zero) begin
                        result           <= {sign_q, EXP_ALL1, MANT_INT};
                        flag_div_by_zero <= 1'b1;
                        done             <= 1'b1;
                    end else if (a_zero || b_inf) begin
                        result <= {sign_q, 79'd0};
                        done   <= 1'b1;
                    end else begin
                        state_reg <= S_DIVIDE;
                    end
                end

                S_DIVIDE: begin
                    rem_reg   <= rem_shift;
                    q_reg     <= q_div_next;
                    count_reg <= count_reg + 1'b1;
                    if (div_last) begin
                        state_reg <= S_NORMALIZE;
                    end
                end

                S_NORMALIZE: begin
                    if (exp_norm >= 17'sd32767) begin
                        result        <= {sign_reg, EXP_ALL1, MANT_INT};
                        flag_overflow <= 1'b1;
                        flag_inexact  <= 1'b1;
                        done          <= 1'b1;
                        state_reg     <= S_IDLE;
                    end else if (exp_norm <= 17'sd0) begin
                        // No denormal output: flush to signed zero.
                        result         <= {sign_reg, 79'd0};
                        flag_underflow <= 1'b1;
                        flag_inexact   <= 1'b1;
                        done           <= 1'b1;
                        state_reg      <= S_IDLE;
                    end else begin
                        exp_reg    <= exp_norm;
                        mant_reg   <= q_norm[QBITS-1 -: 64];
                        guard_reg  <= q_norm[QBITS-65];
                        round_reg  <= q_norm[QBITS-66];
                        sticky_reg <= sticky_norm;
                        state_reg  <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    inexact_reg <= any_lost;
                    if (round_up) begin
                        if (mant_inc[64]) begin
                            mant_reg <= MANT_INT;
                            exp_reg  <= exp_reg + 17'sd1;
                        end else begin
                            mant_reg <= mant_inc[63:0];
                        end
                    end
                    state_reg <= S_PACK;
                end

                S_PACK: begin
                    done         <= 1'b1;
                    flag_inexact <= inexact_reg;
                    if (exp_reg >= 17'sd32767) begin
                        // Rounding carried into the all-ones exponent.
                        result        <= {sign_reg, EXP_ALL1, MANT_INT};
                        flag_overflow <= 1'b1;
                    end else begin
                        result <= {sign_reg, exp_reg[14:0], mant_reg};
                    end
                    state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_ieee754_divide.sv
//------------------------------------------------------------------------------
// tb_fpu_ieee754_divide
//
// Self-checking bench for fpu_ieee754_divide: directed cases with known
// answers, reset abort, enable-while-busy, then random operands checked
// against a behavioural model that divides with wide integer arithmetic.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fpu_ieee754_divide;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [79:0] operand_a;
    logic [79:0] operand_b;
    logic [1:0]  rounding_mode;
    logic [79:0] result;
    logic        done;
    logic        flag_invalid;
    logic        flag_div_by_zero;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int compared   = 0;
    int mismatched = 0;
    int done_pulses = 0;

`ifdef FPU_DIV_EARLY_EXIT_EN
    localparam int LAT_1P5_OVER_1 = 6;
    localparam int LAT_ONE_OVER_ONE = 5;
`else
    localparam int LAT_1P5_OVER_1 = 72;
    localparam int LAT_ONE_OVER_ONE = 72;
`endif

    fpu_ieee754_divide dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .rounding_mode    (rounding_mode),
        .result           (result),
        .done             (done),
        .flag_invalid     (flag_invalid),
        .flag_div_by_zero (flag_div_by_zero),
        .flag_overflow    (flag_overflow),
        .flag_underflow   (flag_underflow),
        .flag_inexact     (flag_inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_pulses <= done_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion of test sequence, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Flag vector order: {invalid, div_by_zero, overflow, underflow, inexact}
    function automatic logic [4:0] flags_now();
        return {flag_invalid, flag_div_by_zero, flag_overflow, flag_underflow, flag_inexact};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Reference model: {flags[4:0], result[79:0]} from the format rules and
    // exact integer division of the mantissas.
    function automatic logic [84:0] ref_div(input logic [79:0] a, input logic [79:0] b,
                                            input logic [1:0] rm);
        logic s;
        logic [14:0] ea, eb;
        logic [63:0] ma, mb, m;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_un, b_un;
        bit g, r, st, inx, up;
        int e;
        logic [135:0] num, quo, rmd;
        s  = a[79] ^ b[79];
        ea = a[78:64]; eb = b[78:64];
        ma = a[63:0];  mb = b[63:0];
        a_nan  = (ea == 15'h7FFF) && (ma != 64'h8000_0000_0000_0000);
        b_nan  = (eb == 15'h7FFF) && (mb != 64'h8000_0000_0000_0000);
        a_inf  = (ea == 15'h7FFF) && (ma == 64'h8000_0000_0000_0000);
        b_inf  = (eb == 15'h7FFF) && (mb == 64'h8000_0000_0000_0000);
        a_zero = (ma == 0);
        b_zero = (mb == 0);
        a_un   = (ma != 0) && (ma < 64'h8000_0000_0000_0000);
        b_un   = (mb != 0) && (mb < 64'h8000_0000_0000_0000);
        if (a_nan || b_nan || a_un || b_un || (a_zero && b_zero) || (a_inf && b_inf))
            return {5'b10000, 1'b0, 15'h7FFF, 64'hC000_0000_0000_0000};
        if (a_inf)
            return {5'b00000, s, 15'h7FFF, 64'h8000_0000_0000_0000};
        if (b_zero)
            return {5'b01000, s, 15'h7FFF, 64'h8000_0000_0000_0000};
        if (a_zero || b_inf)
            return {5'b00000, s, 79'd0};
        e   = int'(ea) - int'(eb) + 16383;
        // 68 quotient bits with the first bit weighted 2^0.
        num = 136'(ma) << 67;
        quo = num / 136'(mb);
        if (quo < (136'(1) << 67)) begin
            num = num << 1;
            quo = num / 136'(mb);
            e   = e - 1;
        end
        rmd = num % 136'(mb);
        if (e >= 32767)
            return {5'b00101, s, 15'h7FFF, 64'h8000_0000_0000_0000};
        if (e <= 0)
            return {5'b00011, s, 79'd0};
        m   = quo[67:4];
        g   = quo[3];
        r   = quo[2];
        st  = (quo[1:0] != 0) || (rmd != 0);
        inx = g || r || st;
        case (rm)
            2'b00:   up = g && (r || st || m[0]);
            2'b01:   up = s && inx;
            2'b10:   up = !s && inx;
            default: up = 1'b0;
        endcase
        if (up) begin
            if (m == 64'hFFFF_FFFF_FFFF_FFFF) begin
                m = 64'h8000_0000_0000_0000;
                e = e + 1;
            end else begin
                m = m + 64'd1;
            end
        end
        if (e >= 32767)
            return {4'b0010, inx, s, 15'h7FFF, 64'h8000_0000_0000_0000};
        return {4'b0000, inx, s, 15'(e), m};
    endfunction

    function automatic logic [79:0] rand_operand();
        logic        s;
        logic [14:0] e;
        logic [63:0] m;
        int          k;
        s = 1'($urandom);
        m = {1'b1, 31'($urandom), 32'($urandom)};
        e = 15'($urandom_range(16300, 16460));
        k = int'($urandom_range(0, 19));
        case (k)
            0: return {s, 15'($urandom_range(0, 32766)), 64'd0};
            1: return {s, 15'h7FFF, 64'h8000_0000_0000_0000};
            2: return {s, 15'h7FFF, 2'b11, 30'($urandom), 32'($urandom)};
            3: return {s, e, 1'b0, 31'($urandom) | 31'd1, 32'($urandom)};
            4: return {s, 15'($urandom_range(32700, 32766)), m};
            5: return {s, 15'($urandom_range(1, 60)), m};
            6, 7: return {s, e, 1'b1, 7'($urandom), 56'd0};
            default: return {s, e, m};
        endcase
    endfunction

    task automatic start_op(input logic [79:0] a, input logic [79:0] b, input logic [1:0] rm);
        @(negedge clk);
        operand_a     = a;
        operand_b     = b;
        rounding_mode = rm;
        enable        = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    // Latency counts edges after the edge that sampled enable; -1 on timeout.
    task automatic wait_done(output logic [79:0] res, output logic [4:0] flg, output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        compared++;
        assert (lat > 0) else begin
            mismatched++;
            $error("FAIL done_timeout: observed no done, expected done within 200 cycles");
        end
        res = result;
        flg = flags_now();
    endtask

    task automatic run_op(input logic [79:0] a, input logic [79:0] b, input logic [1:0] rm,
                          output logic [79:0] res, output logic [4:0] flg, output int lat);
        start_op(a, b, rm);
        wait_done(res, flg, lat);
        $display("op a=%h b=%h rm=%0d -> result=%h flags=%b latency=%0d", a, b, rm, res, flg, lat);
    endtask

    initial begin
        logic [79:0] res;
        logic [4:0]  flg;
        logic [84:0] model;
        logic [79:0] ra, rb;
        logic [1:0]  rrm;
        int          lat;
        int          pulses_snap;

        reset         = 1'b1;
        enable        = 1'b0;
        operand_a     = '0;
        operand_b     = '0;
        rounding_mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 80'd0);
        check("reset_done", 80'(done), 80'd0);
        check("reset_flags", 80'(flags_now()), 80'd0);
        @(negedge clk);
        reset = 1'b0;

        // 6 / 2 = 3, exact
        run_op(80'h4001_C000_0000_0000_0000, 80'h4000_8000_0000_0000_0000, 2'b00, res, flg, lat);
        check("exact_result", res, 80'h4000_C000_0000_0000_0000);
        check("exact_flags", 80'(flg), 80'd0);
        check("exact_latency", 80'(lat), 80'(LAT_1P5_OVER_1));
        @(posedge clk);
        #1;
        check("done_one_cycle", 80'(done), 80'd0);
        check("flags_held_after_done", 80'(flags_now()), 80'd0);

        // 1 / 3 under nearest-even and toward-zero
        run_op(80'h3FFF_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000, 2'b00, res, flg, lat);
        check("third_rne_result", res, 80'h3FFD_AAAA_AAAA_AAAA_AAAB);
        check("third_rne_flags", 80'(flg), 80'h01);
        check("third_latency", 80'(lat), 80'd72);
        run_op(80'h3FFF_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000, 2'b11, res, flg, lat);
        check("third_rz_result", res, 80'h3FFD_AAAA_AAAA_AAAA_AAAA);
        check("third_rz_flags", 80'(flg), 80'h01);
        @(posedge clk);
        #1;
        check("inexact_held", 80'(flag_inexact), 80'd1);

        // Special cases resolve in one edge
        run_op(80'h3FFF_8000_0000_0000_0000, 80'd0, 2'b00, res, flg, lat);
        check("divzero_result", res, 80'h7FFF_8000_0000_0000_0000);
        check("divzero_flags", 80'(flg), 80'h08);
        check("divzero_latency", 80'(lat), 80'd1);
        run_op(80'd0, 80'd0, 2'b00, res, flg, lat);
        check("zero_zero_result", res, 80'h7FFF_C000_0000_0000_0000);
        check("zero_zero_flags", 80'(flg), 80'h10);

        // Exponent range limits
        run_op(80'h7FFE_8000_0000_0000_0000, 80'h3FFE_8000_0000_0000_0000, 2'b00, res, flg, lat);
        check("overflow_result", res, 80'h7FFF_8000_0000_0000_0000);
        check("overflow_flags", 80'(flg), 80'h05);
        run_op(80'h0001_8000_0000_0000_0000, 80'h4000_8000_0000_0000_0000, 2'b00, res, flg, lat);
        check("underflow_result", res, 80'd0);
        check("underflow_flags", 80'(flg), 80'h03);

        // 1.0 / 1.0
        run_op(80'h3FFF_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000, 2'b00, res, flg, lat);
        check("one_result", res, 80'h3FFF_8000_0000_0000_0000);
        check("one_flags", 80'(flg), 80'd0);
        check("one_latency", 80'(lat), 80'(LAT_ONE_OVER_ONE));

        // Reset in divide cycle 30: everything clears, no done follows
        run_op(80'h3FFF_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000, 2'b00, res, flg, lat);
        start_op(80'h3FFF_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000, 2'b00);
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_result", result, 80'd0);
        check("abort_done", 80'(done), 80'd0);
        check("abort_flags", 80'(flags_now()), 80'd0);
        pulses_snap = done_pulses;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_done", 80'(done_pulses - pulses_snap), 80'd0);
        $display("op reset abort at divide cycle 30 -> result=%h done_pulses_after=%0d",
                 result, done_pulses - pulses_snap);

        // Enable pulsed while busy must be ignored
        pulses_snap = done_pulses;
        start_op(80'h3FFF_8000_0000_0000_0000, 80'h4000_C000_0000_0000_0000, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        operand_a = 80'h4005_9000_0000_0000_0000;
        operand_b = 80'h3FFF_8000_0000_0000_0000;
        enable    = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        wait_done(res, flg, lat);
        check("busy_result", res, 80'h3FFD_AAAA_AAAA_AAAA_AAAB);
        check("busy_latency", 80'(lat + 11), 80'd72);
        repeat (100) @(posedge clk);
        #1;
        check("busy_single_done", 80'(done_pulses - pulses_snap), 80'd1);
        $display("op busy enable pulse -> result=%h latency=%0d", res, lat + 11);

        // Random operands against the model
        for (int n = 0; n < 40; n++) begin
            ra    = rand_operand();
            rb    = rand_operand();
            rrm   = 2'($urandom_range(0, 3));
            model = ref_div(ra, rb, rrm);
            run_op(ra, rb, rrm, res, flg, lat);
            check($sformatf("rand%0d_result", n), res, model[79:0]);
            check($sformatf("rand%0d_flags", n), 80'(flg), 80'(model[84:80]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
